// File: rtl/lcb_shutdown_pkg.sv
// Channel numbering and scan FSM encoding shared by the shutdown force and sense scanners.
package lcb_shutdown_pkg;

  localparam int N_SHUTDOWN_CH  = 8;
  localparam int SHUTDOWN_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } scan_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/shutdown_force_scan_phase_timer.sv
// Loadable down-counter that measures the length of one scan phase.
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/shutdown_force_scan.sv
// Serialises an 8-bit shutdown-force vector onto an addressable board latch:
// one channel per SETUP/STROBE/HOLD slot, with a valid/ready vector intake at scan boundaries.
module shutdown_force_scan
  import lcb_shutdown_pkg::*;
#(
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 2,
  parameter bit CONTINUOUS    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      force_en,
  input  logic [N_SHUTDOWN_CH-1:0]  force_vec,
  input  logic                      force_vec_valid,
  output logic                      force_vec_ready,
  output logic [SHUTDOWN_SEL_W-1:0] force_sel,
  output logic                      force_pin,
  output logic                      force_latch,
  output logic                      busy,
  output logic                      scan_done
);

  localparam int TW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;
  localparam logic [SHUTDOWN_SEL_W-1:0] LAST_CH = SHUTDOWN_SEL_W'(N_SHUTDOWN_CH - 1);

  scan_state_e               state_q, state_d;
  logic [SHUTDOWN_SEL_W-1:0] ch_q, ch_d;
  logic [N_SHUTDOWN_CH-1:0]  shadow_q, shadow_d;
  logic                      have_vec_q, have_vec_d;
  logic [SHUTDOWN_SEL_W-1:0] sel_q, sel_d;
  logic                      pin_q, pin_d, latch_q, latch_d;
  logic                      busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic [TW-1:0]             timer_count, timer_val;
  logic                      timer_zero, timer_load;
  logic                      hs;

  phase_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .count_o   (timer_count),
    .zero_o    (timer_zero)
  );

  assign hs = force_vec_valid && ready_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    shadow_d   = hs ? force_vec : shadow_q;
    have_vec_d = have_vec_q | hs;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (force_en && (hs || (CONTINUOUS && have_vec_q))) begin
          state_d = SETUP;
          ch_d    = '0;
        end
      end
      SETUP:  if (timer_zero) state_d = STROBE;
      STROBE: if (timer_zero) state_d = HOLD;
      HOLD: begin
        if (timer_zero) begin
          if (ch_q != LAST_CH) begin
            ch_d    = ch_q + 1'b1;
            state_d = SETUP;
          end else begin
            done_d  = 1'b1;
            ch_d    = '0;
            state_d = (CONTINUOUS || hs) ? SETUP : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable parks immediately; the scan never resumes mid-vector.
    if (!force_en && state_q != IDLE) begin
      state_d = IDLE;
      ch_d    = '0;
      done_d  = 1'b0;
    end

    timer_load = (state_d != state_q);
    unique case (state_d)
      SETUP:   timer_val = TW'(SETUP_CYCLES - 1);
      STROBE:  timer_val = TW'(STROBE_CYCLES - 1);
      HOLD:    timer_val = TW'(HOLD_CYCLES - 1);
      default: timer_val = '0;
    endcase

    // Ready is precomputed for the next cycle: IDLE, or the last cycle of channel 7 HOLD.
    ready_d = (state_d == IDLE) ||
              (state_d == HOLD && ch_d == LAST_CH &&
               ((state_q == HOLD) ? (timer_count == TW'(1)) : (HOLD_CYCLES == 1)));

    busy_d  = (state_d != IDLE);
    sel_d   = busy_d ? ch_d : '0;
    pin_d   = busy_d && shadow_d[ch_d];
    latch_d = (state_d == STROBE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      shadow_q   <= '0;
      have_vec_q <= 1'b0;
      sel_q      <= '0;
      pin_q      <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      shadow_q   <= shadow_d;
      have_vec_q <= have_vec_d;
      sel_q      <= sel_d;
      pin_q      <= pin_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign force_vec_ready = ready_q;
  assign force_sel       = sel_q;
  assign force_pin       = pin_q;
  assign force_latch     = latch_q;
  assign busy            = busy_q;
  assign scan_done       = done_q;

endmodule

// File: tb/tb_shutdown_force_scan.sv
// Directed bench: continuous-mode scanner A and single-shot scanner B, each feeding a model latch.
module tb_shutdown_force_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, a_valid, a_ready, a_pin, a_latch, a_busy, a_done;
  logic [7:0] a_vec;
  logic [2:0] a_sel;
  logic       b_en, b_valid, b_ready, b_pin, b_latch, b_busy, b_done;
  logic [7:0] b_vec;
  logic [2:0] b_sel;
  logic [7:0] model_a, model_b;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  shutdown_force_scan #(.CONTINUOUS(1'b1)) u_a (
    .clk(clk), .rst(rst), .force_en(a_en), .force_vec(a_vec), .force_vec_valid(a_valid),
    .force_vec_ready(a_ready), .force_sel(a_sel), .force_pin(a_pin), .force_latch(a_latch),
    .busy(a_busy), .scan_done(a_done)
  );

  shutdown_force_scan #(.CONTINUOUS(1'b0)) u_b (
    .clk(clk), .rst(rst), .force_en(b_en), .force_vec(b_vec), .force_vec_valid(b_valid),
    .force_vec_ready(b_ready), .force_sel(b_sel), .force_pin(b_pin), .force_latch(b_latch),
    .busy(b_busy), .scan_done(b_done)
  );

  // Board-level addressable latches.
  always @(negedge clk) begin
    if (a_latch) model_a[a_sel] = a_pin;
    if (b_latch) model_b[b_sel] = b_pin;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Checks one full 64-cycle scan of A starting at the next rising edge.
  // Packed word: {ready, busy, scan_done, latch, pin, sel[2:0]}.
  task automatic run_scan(input string tag, input logic [7:0] vec, input bit offer,
                          input logic [7:0] nxt, input bit done_first, input logic [7:0] exp_model);
    int ch, off;
    logic [7:0] exp;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      ch  = c / 8;
      off = c % 8;
      exp = {(c == 63), 1'b1, (c == 0) && done_first, (off == 4 || off == 5), vec[ch], 3'(ch)};
      check($sformatf("%s c%0d", tag, c), {a_ready, a_busy, a_done, a_latch, a_pin, a_sel}, exp);
      if (c == 0) a_valid = 1'b0;
      if (offer && c == 20) begin
        a_valid = 1'b1;
        a_vec   = nxt;
      end
      if (c == 63) check({tag, " model"}, model_a, exp_model);
    end
  endtask

  typedef struct {
    logic [7:0] vec;
    logic [7:0] exp_model;
  } scan_vec_t;

  scan_vec_t tbl [3];

  initial begin
    int n_done, n_latch, done_at;
    bit seen;
    tbl[0] = '{vec: 8'hA5, exp_model: 8'hA5};
    tbl[1] = '{vec: 8'h3C, exp_model: 8'h3C};
    tbl[2] = '{vec: 8'h81, exp_model: 8'h81};

    rst = 1'b1;
    a_en = 1'b1; a_valid = 1'b0; a_vec = 8'h00;
    b_en = 1'b1; b_valid = 1'b0; b_vec = 8'h00;
    model_a = 8'h00; model_b = 8'h00;
    #1;
    check("reset a", {a_ready, a_busy, a_done, a_latch, a_pin, a_sel}, 8'h80);
    check("reset b", {b_ready, b_busy, b_done, b_latch, b_pin, b_sel}, 8'h80);
    @(negedge clk);
    rst = 1'b0;

    // Enabled but never given a vector: must stay parked.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_vec a", {a_ready, a_busy, a_latch, a_done}, 4'b1000);
      check("no_vec b", {b_ready, b_busy, b_latch, b_done}, 4'b1000);
    end

    // Back-to-back scans; each next vector is offered early and must wait for the boundary.
    a_vec = tbl[0].vec;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i < 2) ? i + 1 : i;
      run_scan($sformatf("scan%0d", i), tbl[i].vec, i < 2, tbl[j].vec, i > 0, tbl[i].exp_model);
    end

    // Rescan of 8'h81 without a new vector; abort during channel 3 STROBE.
    for (int c = 0; c < 29; c++) begin
      @(negedge clk);
      if (c == 0) check("rescan done", a_done, 1'b1);
    end
    check("ch3 strobe", {a_latch, a_sel}, {1'b1, 3'd3});
    a_en = 1'b0;
    @(negedge clk);
    check("abort park", {a_ready, a_busy, a_done, a_latch, a_pin, a_sel}, 8'h80);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort idle", {a_busy, a_done, a_latch}, 3'b000);
    end
    a_en = 1'b1;
    run_scan("restart", 8'h81, 1'b0, 8'h00, 1'b0, 8'h81);

    // Disable on the scan boundary: no scan_done; then a vector accepted while disabled.
    a_en = 1'b0;
    @(negedge clk);
    check("boundary abort", {a_ready, a_busy, a_done, a_latch}, 4'b1000);
    a_vec = 8'h5A;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check("idle hs no start", {a_busy, a_latch}, 2'b00);
    a_en = 1'b1;
    run_scan("idle_hs", 8'h5A, 1'b0, 8'h00, 1'b0, 8'h5A);

    // Async reset while the strobe is high.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = a_latch;
    end
    check("strobe seen", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst", {a_ready, a_busy, a_done, a_latch, a_pin, a_sel}, 8'h80);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("post rst idle", {a_busy, a_latch}, 2'b00);
    end

    // Single-shot scanner: exactly one scan of 8'hFF.
    b_vec = 8'hFF;
    b_valid = 1'b1;
    n_done = 0; n_latch = 0; done_at = -1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (c == 0) b_valid = 1'b0;
      if (b_done) begin
        n_done++;
        done_at = c;
      end
      if (b_latch) n_latch++;
    end
    check("b done count", n_done, 1);
    check("b done cycle", done_at, 64);
    check("b latch cycles", n_latch, 16);
    check("b end idle", {b_ready, b_busy, b_latch, b_sel}, 6'b100000);
    check("b model", model_b, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
